laser_rx_deserializer: RTL

- Upstream receive stage of the laser link: takes the raw photodiode bit line and recovers start/stop-framed bytes.
- Oversamples the line, locks to the start bit's falling edge and samples each bit mid-period.
- Presents whole bytes to the downstream buffer over a valid/ready handshake.
- Flags framing errors and overruns.

---
 rtl/laser_rx_deserializer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/laser_rx_deserializer.sv
// Laser link receive deserializer.
// The raw photodiode line is synchronized, then the receiver locks to the start
// bit's falling edge and samples each bit in the middle of its period. Completed
// bytes are held for a valid/ready consumer. Framing errors and overruns are
// reported as single-cycle pulses.
module laser_rx_deserializer #(
    parameter int CLKS_PER_BIT = 8,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 rx_in,
    input  logic                 data_ready,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_error,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS + 1);

    // The start bit is checked half a period in; every later bit is a full period on.
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                 state_q;
    logic [1:0]             sync_q;
    logic                   rx_prev_q;
    logic [CW-1:0]          bit_cnt_q;
    logic [IW-1:0]          bit_idx_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic [DATA_BITS-1:0]   data_q;
    logic                   valid_q;
    logic                   ferr_q;
    logic                   ovr_q;
    logic                   busy_q;

    logic                   rx_s;
    logic                   fall_d;
    logic                   take_d;
    logic [DATA_BITS-1:0]   shift_d;

    assign rx_s    = sync_q[1];
    assign fall_d  = rx_prev_q & ~rx_s;
    assign take_d  = valid_q & data_ready;
    // LSB arrives first, so shifting in from the top leaves bit 0 at the bottom.
    assign shift_d = {rx_s, shift_q[DATA_BITS-1:1]};

    assign data_out    = data_q;
    assign data_valid  = valid_q;
    assign frame_error = ferr_q;
    assign overrun     = ovr_q;
    assign busy        = busy_q;

    // Synchronizer, edge detector, frame FSM and output holding register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q    <= 2'b11;
            rx_prev_q <= 1'b1;
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], rx_in};
            rx_prev_q <= rx_s;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;

            // A consumer transfer clears the holder unless a new byte lands below.
            if (take_d) valid_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (fall_d) begin
                        state_q   <= START;
                        bit_cnt_q <= '0;
                        busy_q    <= 1'b1;
                    end
                end
                START: begin
                    if (bit_cnt_q == HALF_LAST) begin
                        bit_cnt_q <= '0;
                        bit_idx_q <= '0;
                        if (!rx_s) begin
                            state_q <= DATA;
                        end else begin
                            // Line went back high before mid start bit: treat as noise.
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q + CW'(1);
                    end
                end
                DATA: begin
                    if (bit_cnt_q == FULL_LAST) begin
                        bit_cnt_q <= '0;
                        shift_q   <= shift_d;
                        bit_idx_q <= bit_idx_q + IW'(1);
                        if (bit_idx_q == IDX_LAST) state_q <= STOP;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + CW'(1);
                    end
                end
                STOP: begin
                    if (bit_cnt_q == FULL_LAST) begin
                        bit_cnt_q <= '0;
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
                        if (rx_s) begin
                            // Load if the holder is empty or being emptied this cycle.
                            if (!valid_q || take_d) begin
                                data_q  <= shift_q;
                                valid_q <= 1'b1;
                            end else begin
                                ovr_q <= 1'b1;
                            end
                        end else begin
                            ferr_q <= 1'b1;
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule
